dealer_ctrl: RTL and testbench

//  Hold'em dealing sequencer that drives the card deck block.
//  - Starts a shuffle and waits for the deck to report ready.
//  - Deals two hole cards per seat round-robin, then the burn/flop, burn/turn and burn/river

---
 rtl/dealer_ctrl.sv | 142 ++++++++++++++
 tb/tb_dealer_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dealer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dealer_ctrl
// Purpose  : Hold'em dealing sequencer: shuffle, hole cards, burn/board streets.
// Revision : 1.0  initial release
// ============================================================================
module dealer_ctrl #(
    parameter int NUM_PLAYERS = 4,
    parameter bit BURN_EN     = 1'b1,
    parameter int CARD_W      = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              new_hand,
    input  logic              advance,
    output logic              deck_start_shuffle,
    output logic              deck_draw_card,
    input  logic [CARD_W-1:0] deck_top_card,
    input  logic              deck_ready,
    output logic              card_valid,
    output logic [CARD_W-1:0] card_out,
    output logic [3:0]        card_dest,
    output logic [2:0]        street,
    output logic              busy,
    output logic              await_advance
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_SHUF_REQ  = 3'd1;
    localparam logic [2:0] c_SHUF_WAIT = 3'd2;
    localparam logic [2:0] c_HOLE      = 3'd3;
    localparam logic [2:0] c_WAIT_ST   = 3'd4;
    localparam logic [2:0] c_BURN      = 3'd5;
    localparam logic [2:0] c_BOARD     = 3'd6;
    localparam logic [2:0] c_DONE      = 3'd7;

    localparam logic [2:0] c_LAST_SEAT = 3'(NUM_PLAYERS - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [2:0]        r_seat;
    logic              r_round;
    logic [2:0]        r_slot;
    logic [2:0]        r_street;
    logic              r_valid;
    logic [CARD_W-1:0] r_card;
    logic [3:0]        r_dest;
    logic              w_hole_last;
    logic              w_board_last;
    logic              w_deal;

    assign w_hole_last  = r_round && (r_seat == c_LAST_SEAT);
    // Flop ends at slot 2, turn at slot 3, river at slot 4: always one past street.
    assign w_board_last = (r_slot == (r_street + 3'd1));
    assign w_deal       = (r_state == c_HOLE) || (r_state == c_BOARD);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:      if (new_hand) w_next = c_SHUF_REQ;
            c_SHUF_REQ:  w_next = c_SHUF_WAIT;
            c_SHUF_WAIT: if (deck_ready) w_next = c_HOLE;
            c_HOLE:      if (w_hole_last) w_next = c_WAIT_ST;
            c_WAIT_ST: begin
                if (new_hand) begin
                    w_next = c_SHUF_REQ;
                end else if (advance) begin
                    w_next = BURN_EN ? c_BURN : c_BOARD;
                end
            end
            c_BURN:      w_next = c_BOARD;
            c_BOARD: begin
                if (w_board_last) begin
                    w_next = (r_street == 3'd3) ? c_DONE : c_WAIT_ST;
                end
            end
            c_DONE:      if (new_hand) w_next = c_SHUF_REQ;
            default:     w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            r_seat   <= 3'd0;
            r_round  <= 1'b0;
            r_slot   <= 3'd0;
            r_street <= 3'd0;
            r_valid  <= 1'b0;
            r_card   <= '0;
            r_dest   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_valid <= w_deal;
            if (w_deal) begin
                r_card <= deck_top_card;
            end
            case (r_state)
                c_IDLE, c_WAIT_ST, c_DONE: begin
                    if (new_hand) begin
                        r_street <= 3'd0;
                        r_seat   <= 3'd0;
                        r_round  <= 1'b0;
                        r_slot   <= 3'd0;
                    end
                end
                c_HOLE: begin
                    r_dest <= {1'b0, r_seat};
                    if (r_seat == c_LAST_SEAT) begin
                        r_seat  <= 3'd0;
                        r_round <= 1'b1;
                        if (r_round) begin
                            r_street <= 3'd1;
                        end
                    end else begin
                        r_seat <= r_seat + 3'd1;
                    end
                end
                c_BOARD: begin
                    r_dest <= 4'd8 + {1'b0, r_slot};
                    r_slot <= r_slot + 3'd1;
                    if (w_board_last) begin
                        r_street <= r_street + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign deck_start_shuffle = (r_state == c_SHUF_REQ);
    assign deck_draw_card     = w_deal || (r_state == c_BURN);
    assign busy               = (r_state == c_SHUF_REQ) || (r_state == c_SHUF_WAIT) ||
                                (r_state == c_BURN) || w_deal;
    assign await_advance      = (r_state == c_WAIT_ST);
    assign card_valid         = r_valid;
    assign card_out           = r_card;
    assign card_dest          = r_dest;
    assign street             = r_street;

endmodule
`default_nettype wire

// File: tb/tb_dealer_ctrl.sv
`default_nettype none
// Testbench for dealer_ctrl: two instances (burns on / off) driven by a simple
// deck model, a directed operation table and hand-written corner sequences.
module tb_dealer_ctrl;
    localparam int N  = 4;
    localparam int CW = 6;

    typedef struct {
        int inst;
        int nh;
        int adv;
        int shuf;
        int draws;
        int valids;
        int dest0;
        int st;
        int aw;
    } vec_t;

    logic                 clk;
    logic                 deck_rst;
    logic [1:0]           rstn;
    logic [1:0]           nh;
    logic [1:0]           adv;
    logic [1:0]           start;
    logic [1:0]           draw;
    logic [1:0][CW-1:0]   top;
    logic [1:0]           d_ready;
    logic [1:0]           valid;
    logic [1:0][CW-1:0]   cout;
    logic [1:0][3:0]      dest;
    logic [1:0][2:0]      street;
    logic [1:0]           busy;
    logic [1:0]           awaitp;

    int n_cmp;
    int n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    dealer_ctrl #(.NUM_PLAYERS(N), .BURN_EN(1'b1), .CARD_W(CW)) dut0 (
        .clk(clk), .reset_n(rstn[0]), .new_hand(nh[0]), .advance(adv[0]),
        .deck_start_shuffle(start[0]), .deck_draw_card(draw[0]),
        .deck_top_card(top[0]), .deck_ready(d_ready[0]),
        .card_valid(valid[0]), .card_out(cout[0]), .card_dest(dest[0]),
        .street(street[0]), .busy(busy[0]), .await_advance(awaitp[0])
    );

    dealer_ctrl #(.NUM_PLAYERS(N), .BURN_EN(1'b0), .CARD_W(CW)) dut1 (
        .clk(clk), .reset_n(rstn[1]), .new_hand(nh[1]), .advance(adv[1]),
        .deck_start_shuffle(start[1]), .deck_draw_card(draw[1]),
        .deck_top_card(top[1]), .deck_ready(d_ready[1]),
        .card_valid(valid[1]), .card_out(cout[1]), .card_dest(dest[1]),
        .street(street[1]), .busy(busy[1]), .await_advance(awaitp[1])
    );

    // Deck model: 52-cycle shuffle, top card is a seed-dependent permutation.
    int            d_ptr  [2];
    int            d_cnt  [2];
    int            d_seed [2];
    logic [CW-1:0] last_drawn [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (deck_rst) begin
                d_ready[k]    <= 1'b0;
                d_ptr[k]      <= 0;
                d_cnt[k]      <= 0;
                d_seed[k]     <= k * 5;
                last_drawn[k] <= '0;
            end else if (start[k] === 1'b1) begin
                d_ready[k] <= 1'b0;
                d_cnt[k]   <= 0;
                d_ptr[k]   <= 0;
                d_seed[k]  <= (d_seed[k] + 11) % 52;
            end else begin
                if (!d_ready[k]) begin
                    d_cnt[k] <= d_cnt[k] + 1;
                    if (d_cnt[k] == 51) d_ready[k] <= 1'b1;
                end
                if (draw[k] === 1'b1) begin
                    d_ptr[k]      <= d_ptr[k] + 1;
                    last_drawn[k] <= top[k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            top[k] = CW'((d_ptr[k] * 7 + d_seed[k]) % 52);
        end
    end

    // Activity monitor.
    int            n_draw [2];
    int            n_shuf [2];
    int            n_ov   [2];
    int            n_nr   [2];
    int            n_val  [2];
    logic [3:0]    dlog [2][256];
    logic [CW-1:0] clog [2][256];
    logic [CW-1:0] elog [2][256];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (deck_rst) begin
                n_draw[k] <= 0;
                n_shuf[k] <= 0;
                n_ov[k]   <= 0;
                n_nr[k]   <= 0;
                n_val[k]  <= 0;
            end else begin
                if (draw[k] === 1'b1) begin
                    n_draw[k] <= n_draw[k] + 1;
                    if (!d_ready[k]) n_nr[k] <= n_nr[k] + 1;
                end
                if (start[k] === 1'b1) n_shuf[k] <= n_shuf[k] + 1;
                if (start[k] === 1'b1 && draw[k] === 1'b1) n_ov[k] <= n_ov[k] + 1;
                if (valid[k] === 1'b1 && n_val[k] < 256) begin
                    dlog[k][n_val[k]] <= dest[k];
                    clog[k][n_val[k]] <= cout[k];
                    elog[k][n_val[k]] <= last_drawn[k];
                    n_val[k]          <= n_val[k] + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int k);
        return 32'({start[k], draw[k], valid[k], cout[k], dest[k], street[k], busy[k], awaitp[k]});
    endfunction

    task automatic wait_idle(input int k);
        int cyc;
        cyc = 0;
        while (busy[k] !== 1'b0 && cyc < 300) begin
            tick();
            cyc++;
        end
        check("done_in_time", 32'(busy[k]), 0);
        tick();
    endtask

    task automatic do_op(input vec_t v);
        int k, b_draw, b_shuf, b_val, got, e;
        bit dup;
        k      = v.inst;
        b_draw = n_draw[k];
        b_shuf = n_shuf[k];
        b_val  = n_val[k];
        nh[k]  = v.nh[0];
        adv[k] = v.adv[0];
        tick();
        nh[k]  = 1'b0;
        adv[k] = 1'b0;
        if (v.shuf == 1) begin
            check("shuffle_pulse", 32'(start[k]), 1);
            check("street_cleared", 32'(street[k]), 0);
        end
        wait_idle(k);
        got = n_val[k] - b_val;
        check("shuffles", n_shuf[k] - b_shuf, v.shuf);
        check("draws", n_draw[k] - b_draw, v.draws);
        check("valids", got, v.valids);
        for (int i = 0; i < got && i < v.valids; i++) begin
            e = (v.dest0 == 0) ? (i % N) : (v.dest0 + i);
            check("dest", 32'(dlog[k][b_val + i]), e);
            check("card_vs_deck", 32'(clog[k][b_val + i]), 32'(elog[k][b_val + i]));
        end
        check("street", 32'(street[k]), v.st);
        check("await_advance", 32'(awaitp[k]), v.aw);
        if (v.shuf == 1) begin
            dup = 1'b0;
            for (int i = 0; i < got; i++)
                for (int j = i + 1; j < got; j++)
                    if (clog[k][b_val + i] == clog[k][b_val + j]) dup = 1'b1;
            check("hole_distinct", 32'(dup), 0);
        end
    endtask

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_draw, b_shuf, b_val, cyc;
        n_cmp = 0;
        n_bad = 0;
        //          inst nh adv shuf draws valids dest0 st aw
        tbl[0] = '{0, 1, 0, 1, 8, 8, 0,  1, 1};
        tbl[1] = '{0, 0, 1, 0, 4, 3, 8,  2, 1};
        tbl[2] = '{0, 0, 1, 0, 2, 1, 11, 3, 1};
        tbl[3] = '{0, 0, 1, 0, 2, 1, 12, 4, 0};
        tbl[4] = '{0, 0, 1, 0, 0, 0, 0,  4, 0};
        tbl[5] = '{0, 1, 0, 1, 8, 8, 0,  1, 1};
        tbl[6] = '{0, 0, 1, 0, 4, 3, 8,  2, 1};
        tbl[7] = '{0, 1, 1, 1, 8, 8, 0,  1, 1};
        tbl[8] = '{1, 1, 0, 1, 8, 8, 0,  1, 1};
        tbl[9] = '{1, 0, 1, 0, 3, 3, 8,  2, 1};

        deck_rst = 1'b1;
        rstn     = 2'b00;
        nh       = 2'b00;
        adv      = 2'b00;
        repeat (3) tick();
        check("reset_outputs_0", outs(0), 0);
        check("reset_outputs_1", outs(1), 0);
        deck_rst = 1'b0;
        rstn     = 2'b11;
        tick();

        for (int i = 0; i < 10; i++) do_op(tbl[i]);

        // Requests during shuffle wait and during the hole deal are dropped.
        b_draw = n_draw[0];
        b_shuf = n_shuf[0];
        b_val  = n_val[0];
        nh[0] = 1'b1;
        tick();
        nh[0] = 1'b0;
        tick();
        check("in_shuf_wait", 32'({busy[0], start[0], draw[0]}), 32'b100);
        nh[0]  = 1'b1;
        adv[0] = 1'b1;
        tick();
        nh[0]  = 1'b0;
        adv[0] = 1'b0;
        check("drop_wait_outs", 32'({busy[0], start[0], draw[0], street[0]}), 32'b1_0_0_000);
        cyc = 0;
        while (draw[0] !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("hole_started", 32'(draw[0]), 1);
        adv[0] = 1'b1;
        tick();
        adv[0] = 1'b0;
        wait_idle(0);
        check("drop_shuffles", n_shuf[0] - b_shuf, 1);
        check("drop_draws", n_draw[0] - b_draw, 8);
        check("drop_valids", n_val[0] - b_val, 8);
        check("drop_street", 32'(street[0]), 1);
        check("drop_await", 32'(awaitp[0]), 1);

        // Reset asserted on the third hole draw, then a fresh no-burn hand.
        b_draw = n_draw[1];
        nh[1] = 1'b1;
        tick();
        nh[1] = 1'b0;
        cyc = 0;
        while (!(draw[1] === 1'b1 && n_draw[1] - b_draw == 2) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("third_draw_found", 32'(draw[1]), 1);
        rstn[1] = 1'b0;
        tick();
        rstn[1] = 1'b1;
        check("mid_reset_outputs", outs(1), 0);
        tick();
        check("stays_idle", outs(1), 0);
        do_op(tbl[8]);
        do_op(tbl[9]);

        for (int k = 0; k < 2; k++) begin
            check("shuffle_draw_overlap", n_ov[k], 0);
            check("draw_while_not_ready", n_nr[k], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
